// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared types and helpers for the parametrised Viterbi
//               decoder: control state type, encoder parity, 2-bit Hamming
//               distance and the frame-init path metric.
// Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    // Control states: FILL while the decision depth is filling, RUN afterwards
    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } vit_state_e;

    // Non-zero states start 2^(MW-2) above state 0 at frame init
    localparam int unsigned PM_INIT_EXP_OFFSET = 2;

    function automatic int unsigned frame_init_metric(input int unsigned mw);
        return 32'd1 << (mw - PM_INIT_EXP_OFFSET);
    endfunction

    // Parity of the tapped encoder register bits
    function automatic logic conv_parity(input logic [15:0] reg_v, input logic [15:0] poly);
        return ^(reg_v & poly);
    endfunction

    // Hamming distance between two 2-bit symbols (0..2)
    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_acs.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_acs
// Description : One add-compare-select cell: adds the branch metric to each
//               predecessor metric and keeps the smaller sum.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_acs #(
    parameter int unsigned MW = 8
) (
    input  logic [MW-1:0] pm0,
    input  logic [MW-1:0] pm1,
    input  logic [1:0]    bm0,
    input  logic [1:0]    bm1,
    output logic [MW-1:0] pm_new,
    output logic          sel
);

    logic [MW-1:0] cand0;
    logic [MW-1:0] cand1;

    // Add, compare, select; a tie keeps the even predecessor (sel = 0)
    always_comb begin
        cand0  = pm0 + MW'(bm0);
        cand1  = pm1 + MW'(bm1);
        sel    = (cand1 < cand0);
        pm_new = sel ? cand1 : cand0;
    end

endmodule
`default_nettype wire

// File: rtl/viterbi_dec_param.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_dec_param
// Description : Parametrised hard-decision rate-1/2 Viterbi decoder with
//               fully parallel ACS and register-exchange survivors.
//               Optional macro VITERBI_BEST_STATE_EN: decode from the state
//               with the lowest registered metric instead of state 0.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_dec_param
    import viterbi_pkg::*;
#(
    parameter int unsigned  K  = 7,
    parameter logic [K-1:0] G0 = 7'o171,
    parameter logic [K-1:0] G1 = 7'o133,
    parameter int unsigned  TB = 35,
    parameter int unsigned  MW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_sym,
    input  logic       in_first,
    output logic       out_valid,
    output logic       out_bit,
    output logic       ready
);

    localparam int unsigned    SW       = K - 1;
    localparam int unsigned    NS       = 1 << SW;
    localparam int unsigned    CW       = $clog2(TB + 1);
    localparam logic [MW-1:0]  PM_INIT  = MW'(frame_init_metric(MW));
    localparam logic [CW-1:0]  CNT_LAST = CW'(TB - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(TB);

    vit_state_e               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NS-1:0][MW-1:0]    pm_q, pm_d, pm_src, acs_pm;
    logic [NS-1:0][TB-1:0]    path_q, path_d, path_src, acs_path;
    logic [NS-1:0]            acs_sel;
    logic                     out_valid_q, out_valid_d;
    logic                     out_bit_q, out_bit_d;
    logic                     norm_all_msb;
    logic [SW-1:0]            best_idx;

    // ACS sources: a symbol that opens a frame sees the frame-init metrics/paths
    always_comb begin
        pm_src   = pm_q;
        path_src = path_q;
        if (in_first) begin
            for (int i = 0; i < NS; i++) begin
                pm_src[i] = (i == 0) ? '0 : PM_INIT;
            end
            path_src = '0;
        end
    end

    // One ACS cell and survivor update per next state n, with u = n[K-2]
    for (genvar gi = 0; gi < NS; gi++) begin : g_state
        localparam logic [SW-1:0] N_IDX  = SW'(gi);
        localparam logic          U_BIT  = N_IDX[SW-1];
        localparam logic [SW-1:0] P0_IDX = {N_IDX[SW-2:0], 1'b0};
        localparam logic [SW-1:0] P1_IDX = {N_IDX[SW-2:0], 1'b1};
        localparam logic [1:0]    EXP0   = {conv_parity(16'({U_BIT, P0_IDX}), 16'(G0)),
                                            conv_parity(16'({U_BIT, P0_IDX}), 16'(G1))};
        localparam logic [1:0]    EXP1   = {conv_parity(16'({U_BIT, P1_IDX}), 16'(G0)),
                                            conv_parity(16'({U_BIT, P1_IDX}), 16'(G1))};

        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = hamming2(in_sym, EXP0);
        assign bm1 = hamming2(in_sym, EXP1);

        viterbi_acs #(
            .MW (MW)
        ) u_acs (
            .pm0    (pm_src[P0_IDX]),
            .pm1    (pm_src[P1_IDX]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_new (acs_pm[gi]),
            .sel    (acs_sel[gi])
        );

        assign acs_path[gi] = {(acs_sel[gi] ? path_src[P1_IDX][TB-2:0]
                                            : path_src[P0_IDX][TB-2:0]), U_BIT};
    end

    // Normalise when every new metric has its MSB set
    always_comb begin
        norm_all_msb = 1'b1;
        for (int i = 0; i < NS; i++) begin
            norm_all_msb = norm_all_msb & acs_pm[i][MW-1];
        end
    end

`ifdef VITERBI_BEST_STATE_EN
    logic [MW-1:0] best_pm;

    // Lowest-index state holding the minimum registered metric
    always_comb begin
        best_idx = '0;
        best_pm  = pm_q[0];
        for (int i = 1; i < NS; i++) begin
            if (pm_q[i] < best_pm) begin
                best_pm  = pm_q[i];
                best_idx = SW'(i);
            end
        end
    end
`else
    assign best_idx = '0;
`endif

    // Next-state: ACS results, symbol counter, FILL/RUN control and decision output
    always_comb begin
        pm_d        = pm_q;
        path_d      = path_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        if (in_valid) begin
            for (int i = 0; i < NS; i++) begin
                pm_d[i] = acs_pm[i];
                if (norm_all_msb) begin
                    pm_d[i][MW-1] = 1'b0;
                end
            end
            path_d = acs_path;
            if (in_first) begin
                // New frame: the old frame's undrained decisions are dropped
                cnt_d   = CW'(1);
                state_d = FILL;
            end else begin
                if (state_q == RUN) begin
                    out_valid_d = 1'b1;
                    out_bit_d   = path_q[best_idx][TB-1];
                end
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
        end
    end

    // Registers; reset loads the frame-init metrics and clears everything else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            for (int i = 0; i < NS; i++) begin
                pm_q[i] <= (i == 0) ? '0 : PM_INIT;
            end
            path_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pm_q        <= pm_d;
            path_q      <= path_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign ready     = (state_q == RUN);

endmodule
`default_nettype wire

// File: doc/viterbi_dec_param.md
# viterbi_dec_param

Parametrised, single-clock, hard-decision Viterbi decoder for rate-1/2 convolutional codes with programmable constraint length, generator polynomials and decision depth. It replaces the fixed K=7, dual-clock control/compute pair with one clock domain. It uses fully parallel add-compare-select (ACS) and register-exchange survivor paths. Decoding continues across frames, with per-frame restart under `in_first`. The block sits between the demodulator's hard-bit slicer and the frame deframer.

## Interface
- `K`, default 7: constraint length. Range 3..9; the decoder has 2^(K-1) states.
- `G0`, default 7'o171: generator polynomial for code bit c0. K bits wide; bit K-1 taps the current input.
- `G1`, default 7'o133: generator polynomial for code bit c1.
- `TB`, default 35: decision depth in symbols (path register length). Must be ≥ 2.
- `MW`, default 8: path-metric width. Must satisfy 2^(MW-2) > 2·K.

Ports:
- `clk` in 1: sole clock. Rising edge.
- `rst` in 1: reset. Asynchronous, active-low.
- `in_valid` in 1: a code symbol is presented this cycle. The block accepts every cycle, so there is no backpressure.
- `in_sym` in 2: code symbol; [1] = c0, [0] = c1.
- `in_first` in 1: qualified by `in_valid`; this symbol starts a new frame.
- `out_valid` out 1: one-cycle pulse; `out_bit` is valid.
- `out_bit` out 1: decoded information bit.
- `ready` out 1: high once the decision depth is filled in the current frame.

## Operation
- **State convention.** State s is K-1 bits, with s[K-2] the newest input. Encoder register = {u, s}; next state = {u, s[K-2:1]}. c0 = ^({u,s} & G0), c1 = ^({u,s} & G1).
- **Branch metric.** Hamming distance (0..2) between `in_sym` and the expected {c0,c1}.
- **ACS.** For next state n, with u = n[K-2]:
  - Predecessors are p0 = {n[K-3:0],0} and p1 = {n[K-3:0],1}.
  - pm'[n] = min(pm[p0]+bm0, pm[p1]+bm1).
  - On a tie, p0 is selected.
- **Survivors.** path'[n] = {path[sel][TB-2:0], u}.
- **Normalisation.** If the MSB of every new metric is 1, all MSBs are cleared in the same update. Metrics never wrap.
- **Frame init.** Applies at reset and when a symbol is accepted with `in_first`=1.
  - pm[0] = 0; every other state gets pm = 2^(MW-2).
  - All paths = 0; symbol counter n = 0.
  - With `in_first`, the first symbol is ACS-processed using these initial values.
- **Control FSM.**
  - FILL: n < TB, `ready` = 0.
  - RUN: n ≥ TB, `ready` = 1.
  - FILL→RUN occurs when the symbol with n = TB-1 is accepted.
  - Any → FILL on frame init. The counter saturates at TB.
- **Output selection.** On acceptance of symbol n (n ≥ TB, counted before the update):
  - `out_bit` <= path[b][TB-1] from the pre-update registers, where b is the selected state (see Configuration).
  - This is the decision for symbol n-TB.
- **Frame end.** No flush exists. Upstream appends K-1 tail zeros plus TB zero symbols to drain a frame.
- **Simultaneous events.** An `in_first` symbol arriving while in RUN emits no output; the old frame's undrained bits are discarded.

## Timing
- Reset values:
  - `out_valid` = 0, `out_bit` = 0, `ready` = 0.
  - FSM = FILL; metrics and paths at frame-init values.
- Symbol processing takes one cycle. Metrics, paths, counter and outputs all register on the edge where `in_valid`=1.
- `out_valid` pulses on the cycle after accepting symbol n ≥ TB. Decoding latency is TB+1 accepted symbols.
- Gaps in `in_valid` freeze all state; `out_valid` stays 0 during gaps.
- `ready` rises on the cycle after acceptance of symbol TB-1.
- Reset asserted mid-frame clears everything immediately. The first symbol after reset is decoded as n = 0 whether or not `in_first` is set.

## Configuration
- `VITERBI_BEST_STATE_EN` defined:
  - b = argmin of the registered metrics, lowest index on a tie.
  - This adds a comparator tree.
- Not defined:
  - b = 0 always.
  - Requires zero-terminated input for full performance.

## Structure
- Package `viterbi_pkg` holds:
  - FSM state type {FILL, RUN}.
  - Function `conv_parity(reg, poly)`.
  - Function `hamming2(a, b)`.
  - The frame-init metric constant.
- Sub-module `viterbi_acs`:
  - One instance per state, via generate.
  - Inputs: two predecessor metrics, two branch metrics.
  - Outputs: new metric and select bit.

## Test plan
- Reset, then K=7, stream of 100 symbols of 00: `out_bit` = 0 for all 65 outputs; `ready` rises after symbol 34; pm[0] remains 0.
- K=3, G0=3'o7, G1=3'o5, TB=4, symbols 11,10,00,01,01,11,00,00,00,00 (first with `in_first`): outputs 1,0,1,1,0,0.
- Same stream with symbol 2 changed to 10 (single bit error): identical output 1,0,1,1,0,0.
- `in_first` asserted on symbol 7 mid-RUN: no `out_valid` for that cycle; `ready` drops; the next output appears TB symbols later.
- `rst` asserted low for 1 cycle mid-frame: all outputs 0 asynchronously; decoding restarts at n = 0.
- 10,000 random symbols with a 30% bit-error rate: no metric wraps (checked by assertion); normalisation fires; with `VITERBI_BEST_STATE_EN`, b always indexes a minimum metric.
